// File: rtl/fifo_flags_if.sv
// Channel-side bundle of a fifo_flags instance: push/pop requests, popped
// data and the occupancy/status flags consumed by the flow-control FSM.
interface fifo_flags_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
) ();

  logic                  wr_enable;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_enable;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic [ADDR_WIDTH:0]   fifo_count;
  logic                  FIFOfull;
  logic                  FIFOempty;
  logic                  FIFOpause;
  logic                  FIFOcontinue;
  logic                  FIFOerror;

  // Producer/consumer of the FIFO (drives requests, observes status).
  modport master (
    output wr_enable, data_in, rd_enable,
    input  data_out, valid_out, fifo_count,
    input  FIFOfull, FIFOempty, FIFOpause, FIFOcontinue, FIFOerror
  );

  // The FIFO itself.
  modport slave (
    input  wr_enable, data_in, rd_enable,
    output data_out, valid_out, fifo_count,
    output FIFOfull, FIFOempty, FIFOpause, FIFOcontinue, FIFOerror
  );

endinterface

// File: rtl/fifo_flags.sv
// Small virtual-channel FIFO with high/low watermark flags (pause/continue
// hysteresis), full/empty decodes and a sticky overflow/underflow error.
module fifo_flags #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int HIGH_TH    = 3,
  parameter int LOW_TH     = 1
) (
  input  logic         clk,
  input  logic         reset,   // asynchronous, active-low
  fifo_flags_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   HIGH_C  = (ADDR_WIDTH+1)'(HIGH_TH);
  localparam logic [ADDR_WIDTH:0]   LOW_C   = (ADDR_WIDTH+1)'(LOW_TH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic                  r_error;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_err_set;
  logic [ADDR_WIDTH:0]   w_count_next;

  // Flags decode the registered count, so they move with fifo_count.
  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  // A pop frees a slot in the same cycle, so push-while-full is legal with it.
  assign w_pop     = bus.rd_enable && !w_empty;
  assign w_push    = bus.wr_enable && (!w_full || w_pop);
  assign w_err_set = (bus.wr_enable && w_full && !w_pop) ||
                     (bus.rd_enable && w_empty);

  // Occupancy update; push and pop together leave the count unchanged.
  always_comb begin
    // NOTE: default first so every path assigns w_count_next and no latch is inferred.
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + CNT_ONE;
    else if (w_pop && !w_push) w_count_next = r_count - CNT_ONE;
  end

  // Storage array written on accepted pushes.
  // NOTE: the array has no reset; its contents are unreachable until written,
  // and leaving it out of the reset lets it map onto plain RAM/register files.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.data_in;
  end

  // Pointers, count, popped word, valid strobe and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      r_valid_out <= w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
        r_data_out <= r_mem[r_rd_ptr];
      end
      if (w_err_set) r_error <= 1'b1;
    end
  end

  assign bus.data_out     = r_data_out;
  assign bus.valid_out    = r_valid_out;
  assign bus.fifo_count   = r_count;
  assign bus.FIFOfull     = w_full;
  assign bus.FIFOempty    = w_empty;
  assign bus.FIFOpause    = (r_count >= HIGH_C);
  assign bus.FIFOcontinue = (r_count <= LOW_C);
  assign bus.FIFOerror    = r_error;

endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench for fifo_flags at default parameters (DEPTH 4, HIGH 3, LOW 1).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_fifo_flags;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fifo_flags_if #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) bus ();

  fifo_flags #(
    .DATA_WIDTH(6), .ADDR_WIDTH(2), .HIGH_TH(3), .LOW_TH(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against hand-computed values.
  task automatic check_all(input string tag, input int cnt,
                           input bit full, input bit empty, input bit pause,
                           input bit cont, input bit err, input bit valid,
                           input logic [5:0] dout);
    check({tag, ".count"},    32'(bus.fifo_count),   32'(cnt));
    check({tag, ".full"},     32'(bus.FIFOfull),     32'(full));
    check({tag, ".empty"},    32'(bus.FIFOempty),    32'(empty));
    check({tag, ".pause"},    32'(bus.FIFOpause),    32'(pause));
    check({tag, ".continue"}, 32'(bus.FIFOcontinue), 32'(cont));
    check({tag, ".error"},    32'(bus.FIFOerror),    32'(err));
    check({tag, ".valid"},    32'(bus.valid_out),    32'(valid));
    check({tag, ".data"},     32'(bus.data_out),     32'(dout));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit wr, input logic [5:0] din, input bit rd);
    bus.wr_enable = wr;
    bus.data_in   = din;
    bus.rd_enable = rd;
  endtask

  initial begin
    // 1. Reset held for two edges
    reset = 1'b0;
    drive(1'b0, 6'h00, 1'b0);
    step();
    step();
    check_all("reset", 0, 0, 1, 0, 1, 0, 0, 6'h00);
    reset = 1'b1;

    // 2. Fill 0x11, 0x22, 0x33, 0x04
    drive(1'b1, 6'h11, 1'b0); step();
    check_all("fill1", 1, 0, 0, 0, 1, 0, 0, 6'h00);
    drive(1'b1, 6'h22, 1'b0); step();
    check_all("fill2", 2, 0, 0, 0, 0, 0, 0, 6'h00);
    drive(1'b1, 6'h33, 1'b0); step();
    check_all("fill3", 3, 0, 0, 1, 0, 0, 0, 6'h00);
    drive(1'b1, 6'h04, 1'b0); step();
    check_all("fill4", 4, 1, 0, 1, 0, 0, 0, 6'h00);

    // 3. Drain in order, then wrap the pointers with 0x2A
    drive(1'b0, 6'h00, 1'b1); step();
    check_all("drain1", 3, 0, 0, 1, 0, 0, 1, 6'h11);
    step();
    check_all("drain2", 2, 0, 0, 0, 0, 0, 1, 6'h22);
    step();
    check_all("drain3", 1, 0, 0, 0, 1, 0, 1, 6'h33);
    step();
    check_all("drain4", 0, 0, 1, 0, 1, 0, 1, 6'h04);
    drive(1'b1, 6'h2A, 1'b0); step();
    check_all("wrap_push", 1, 0, 0, 0, 1, 0, 0, 6'h04);
    drive(1'b0, 6'h00, 1'b1); step();
    check_all("wrap_pop", 0, 0, 1, 0, 1, 0, 1, 6'h2A);
    drive(1'b0, 6'h00, 1'b0); step();
    check_all("idle_hold", 0, 0, 1, 0, 1, 0, 0, 6'h2A);

    // 4. Overflow from full: 0x3F must be dropped
    drive(1'b1, 6'h01, 1'b0); step();
    drive(1'b1, 6'h02, 1'b0); step();
    drive(1'b1, 6'h03, 1'b0); step();
    drive(1'b1, 6'h05, 1'b0); step();
    check_all("ovf_full", 4, 1, 0, 1, 0, 0, 0, 6'h2A);
    drive(1'b1, 6'h3F, 1'b0); step();
    check_all("ovf", 4, 1, 0, 1, 0, 1, 0, 6'h2A);
    drive(1'b0, 6'h00, 1'b1); step();
    check_all("ovf_pop1", 3, 0, 0, 1, 0, 1, 1, 6'h01);
    step();
    check_all("ovf_pop2", 2, 0, 0, 0, 0, 1, 1, 6'h02);
    step();
    check_all("ovf_pop3", 1, 0, 0, 0, 1, 1, 1, 6'h03);
    step();
    check_all("ovf_pop4", 0, 0, 1, 0, 1, 1, 1, 6'h05);
    drive(1'b0, 6'h00, 1'b0);

    // Clear the sticky error
    reset = 1'b0;
    step();
    check_all("reset2", 0, 0, 1, 0, 1, 0, 0, 6'h00);
    reset = 1'b1;

    // 5a. Push and pop together at full
    drive(1'b1, 6'h21, 1'b0); step();
    drive(1'b1, 6'h22, 1'b0); step();
    drive(1'b1, 6'h23, 1'b0); step();
    drive(1'b1, 6'h24, 1'b0); step();
    check_all("sim_full_pre", 4, 1, 0, 1, 0, 0, 0, 6'h00);
    drive(1'b1, 6'h15, 1'b1); step();
    check_all("sim_full", 4, 1, 0, 1, 0, 0, 1, 6'h21);
    drive(1'b0, 6'h00, 1'b1); step();
    check_all("sim_drain1", 3, 0, 0, 1, 0, 0, 1, 6'h22);
    step();
    check_all("sim_drain2", 2, 0, 0, 0, 0, 0, 1, 6'h23);
    step();
    check_all("sim_drain3", 1, 0, 0, 0, 1, 0, 1, 6'h24);
    step();
    check_all("sim_drain4", 0, 0, 1, 0, 1, 0, 1, 6'h15);

    // 5b. Push and pop together at empty: underflow, no bypass
    drive(1'b1, 6'h07, 1'b1); step();
    check_all("sim_empty", 1, 0, 0, 0, 1, 1, 0, 6'h15);
    drive(1'b0, 6'h00, 1'b1); step();
    check_all("sim_empty_pop", 0, 0, 1, 0, 1, 1, 1, 6'h07);

    // 6. Mid-cycle asynchronous reset at count 3
    drive(1'b1, 6'h31, 1'b0); step();
    drive(1'b1, 6'h32, 1'b0); step();
    drive(1'b1, 6'h33, 1'b0); step();
    drive(1'b1, 6'h34, 1'b0); step();
    drive(1'b0, 6'h00, 1'b1); step();
    check_all("mid_pre", 3, 0, 0, 1, 0, 1, 1, 6'h31);
    drive(1'b1, 6'h3E, 1'b0);
    #3 reset = 1'b0;
    #1;
    check_all("mid_async", 0, 0, 1, 0, 1, 0, 0, 6'h00);
    step();
    check_all("mid_held", 0, 0, 1, 0, 1, 0, 0, 6'h00);
    drive(1'b0, 6'h00, 1'b0);
    reset = 1'b1;
    drive(1'b1, 6'h2B, 1'b0); step();
    check_all("post_push", 1, 0, 0, 0, 1, 0, 0, 6'h00);
    drive(1'b0, 6'h00, 1'b1); step();
    check_all("post_pop", 0, 0, 1, 0, 1, 0, 1, 6'h2B);
    drive(1'b0, 6'h00, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
